// File: rtl/hp_life_sequencer.sv
// hp_life_sequencer: turns raw Pac-Man/monster overlap into single hit
// pulses, runs the death pause, respawn blink window and game-over/restart.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start_of_frame  one-cycle pulse per video frame
//   raw_collision   level, sprite overlap (may stay high for many cycles)
//   HP              current HP from the HP counter
//   restart_req     level, restart key (edge-detected in game-over)
//   collision_mp    one-cycle hit pulse to the HP counter
//   stop_gameN      active-low gameplay freeze
//   respawn         one-cycle pulse, movers reload start positions
//   hp_reload       one-cycle pulse, HP counter reloads initial HP
//   pacman_blank    high hides the Pac-Man sprite
//   game_over       high while in game-over
module hp_life_sequencer #(
    parameter int DEATH_FRAMES  = 60,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_of_frame,
    input  logic       raw_collision,
    input  logic [1:0] HP,
    input  logic       restart_req,
    output logic       collision_mp,
    output logic       stop_gameN,
    output logic       respawn,
    output logic       hp_reload,
    output logic       pacman_blank,
    output logic       game_over
);

    localparam logic [2:0] S_PLAY      = 3'd0;
    localparam logic [2:0] S_HIT       = 3'd1;
    localparam logic [2:0] S_DYING     = 3'd2;
    localparam logic [2:0] S_RESPAWN   = 3'd3;
    localparam logic [2:0] S_INVULN    = 3'd4;
    localparam logic [2:0] S_GAME_OVER = 3'd5;
    localparam logic [2:0] S_RESTART   = 3'd6;

    localparam logic [CNT_W-1:0] DEATH_LAST  = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [CNT_W-1:0] INVULN_LAST = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [CNT_W-1:0] BLINK_LEN   = CNT_W'(BLINK_FRAMES);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_next_blank;
    logic             w_blink_edge;
    logic             w_restart_rise;
    logic             r_restart_d;
    logic             r_collision_mp;
    logic             r_stop_gameN;
    logic             r_respawn;
    logic             r_hp_reload;
    logic             r_pacman_blank;
    logic             r_game_over;

    assign w_cnt_inc      = r_cnt + CNT_W'(1);
    assign w_blink_edge   = (w_cnt_inc % BLINK_LEN) == '0;
    // r_restart_d tracks the key in every state, so a key already held
    // when game-over is entered shows no rising edge until re-pressed.
    assign w_restart_rise = restart_req & ~r_restart_d;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_blank = r_pacman_blank;
        unique case (r_state)
            S_PLAY: begin
                w_next_cnt   = '0;
                w_next_blank = 1'b0;
                if (raw_collision)
                    w_next_state = S_HIT;
            end
            S_HIT: begin
                w_next_state = S_DYING;
                w_next_cnt   = '0;
            end
            S_DYING: begin
                if (start_of_frame) begin
                    if (r_cnt == DEATH_LAST) begin
                        w_next_cnt   = '0;
                        w_next_state = (HP == 2'd0) ? S_GAME_OVER
                                                    : S_RESPAWN;
                    end else begin
                        w_next_cnt = w_cnt_inc;
                    end
                end
            end
            S_RESPAWN: begin
                w_next_state = S_INVULN;
                w_next_cnt   = '0;
                w_next_blank = 1'b1;
            end
            S_INVULN: begin
                if (start_of_frame) begin
                    if (r_cnt == INVULN_LAST) begin
                        w_next_state = S_PLAY;
                        w_next_cnt   = '0;
                        w_next_blank = 1'b0;
                    end else begin
                        w_next_cnt = w_cnt_inc;
                        if (w_blink_edge)
                            w_next_blank = ~r_pacman_blank;
                    end
                end
            end
            S_GAME_OVER: begin
                w_next_cnt   = '0;
                w_next_blank = 1'b0;
                if (w_restart_rise)
                    w_next_state = S_RESTART;
            end
            S_RESTART: begin
                w_next_state = S_PLAY;
                w_next_cnt   = '0;
                w_next_blank = 1'b0;
            end
            default: begin
                w_next_state = S_PLAY;
                w_next_cnt   = '0;
                w_next_blank = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so each registered output
    // lines up with the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_PLAY;
            r_cnt          <= '0;
            r_restart_d    <= 1'b0;
            r_collision_mp <= 1'b0;
            r_stop_gameN   <= 1'b1;
            r_respawn      <= 1'b0;
            r_hp_reload    <= 1'b0;
            r_pacman_blank <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_cnt          <= w_next_cnt;
            r_restart_d    <= restart_req;
            r_collision_mp <= (w_next_state == S_HIT);
            r_stop_gameN   <= (w_next_state == S_PLAY)
                            | (w_next_state == S_HIT)
                            | (w_next_state == S_INVULN);
            r_respawn      <= (w_next_state == S_RESPAWN)
                            | (w_next_state == S_RESTART);
            r_hp_reload    <= (w_next_state == S_RESTART);
            r_pacman_blank <= w_next_blank;
            r_game_over    <= (w_next_state == S_GAME_OVER);
        end
    end

    assign collision_mp = r_collision_mp;
    assign stop_gameN   = r_stop_gameN;
    assign respawn      = r_respawn;
    assign hp_reload    = r_hp_reload;
    assign pacman_blank = r_pacman_blank;
    assign game_over    = r_game_over;

endmodule

// File: tb/tb_hp_life_sequencer.sv
// tb_hp_life_sequencer: directed sequence with randomized frame period and
// timing, checked against frame-count arithmetic and an HP counter model.
module tb_hp_life_sequencer;

    localparam int DEATH  = 60;
    localparam int INVULN = 120;
    localparam int BLINK  = 8;
    localparam int LIMIT  = 4000;

    logic       clk;
    logic       reset;
    logic       start_of_frame;
    logic       raw_collision;
    logic [1:0] hp;
    logic       restart_req;
    logic       collision_mp;
    logic       stop_gameN;
    logic       respawn;
    logic       hp_reload;
    logic       pacman_blank;
    logic       game_over;

    int n_checks;
    int n_fail;
    int fp;
    int phase;
    int n_coll;
    int n_resp;
    int n_reload;
    int dying_frames;
    int inv_frames;
    int blank_q[$];
    int exp_q[$];

    hp_life_sequencer #(
        .DEATH_FRAMES (DEATH),
        .INVULN_FRAMES(INVULN),
        .BLINK_FRAMES (BLINK),
        .CNT_W        (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_of_frame(start_of_frame),
        .raw_collision (raw_collision),
        .HP            (hp),
        .restart_req   (restart_req),
        .collision_mp  (collision_mp),
        .stop_gameN    (stop_gameN),
        .respawn       (respawn),
        .hp_reload     (hp_reload),
        .pacman_blank  (pacman_blank),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive the frame pulse, advance, model the HP counter and
    // keep event tallies used by the high-level checks.
    task automatic step();
        logic p_c, p_s, p_r, p_hr, p_b;
        p_c  = collision_mp;
        p_s  = stop_gameN;
        p_r  = respawn;
        p_hr = hp_reload;
        p_b  = pacman_blank;
        start_of_frame = (phase == fp - 1);
        phase = (phase + 1) % fp;
        @(posedge clk);
        #1;
        if (p_hr)
            hp = 2'd3;
        else if (p_c && p_s && hp != 2'd0)
            hp = hp - 2'd1;
        if (collision_mp) n_coll++;
        if (respawn) n_resp++;
        if (hp_reload) n_reload++;
        if (start_of_frame && !p_s && !p_r) dying_frames++;
        if (start_of_frame && !p_r) inv_frames++;
        if (respawn) inv_frames = 0;
        if (pacman_blank != p_b) blank_q.push_back(inv_frames);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_collision_mp"}, collision_mp, 1'b0);
        check({pfx, "_stop_gameN"}, stop_gameN, 1'b1);
        check({pfx, "_respawn"}, respawn, 1'b0);
        check({pfx, "_hp_reload"}, hp_reload, 1'b0);
        check({pfx, "_pacman_blank"}, pacman_blank, 1'b0);
        check({pfx, "_game_over"}, game_over, 1'b0);
    endtask

    task automatic run_invuln(input string tag);
        int b;
        b = 0;
        blank_q.delete();
        while (blank_q.size() < exp_q.size() && b < LIMIT) begin
            step();
            b++;
        end
        check({tag, "_blink_count"}, blank_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < blank_q.size())
                check({tag, "_blink_frame"}, blank_q[i], exp_q[i]);
        check({tag, "_blank_play"}, pacman_blank, 1'b0);
        check({tag, "_stop_play"}, stop_gameN, 1'b1);
    endtask

    task automatic wait_respawn(input string tag);
        int b;
        b = 0;
        while (!respawn && b < LIMIT) begin
            step();
            b++;
        end
        check({tag, "_respawn_seen"}, respawn, 1'b1);
    endtask

    initial begin
        int b;
        int blank_lvl;
        n_checks = 0;
        n_fail = 0;
        n_coll = 0;
        n_resp = 0;
        n_reload = 0;
        dying_frames = 0;
        inv_frames = 0;
        phase = 0;
        fp = $urandom_range(2, 4);
        reset = 1'b1;
        start_of_frame = 1'b0;
        raw_collision = 1'b0;
        restart_req = 1'b0;
        hp = 2'd3;

        // Blink change points: entry to 1, toggles, forced 0 at PLAY.
        exp_q.push_back(0);
        blank_lvl = 1;
        for (int k = 1; k < INVULN; k++)
            if (k % BLINK == 0) begin
                exp_q.push_back(k);
                blank_lvl = 1 - blank_lvl;
            end
        if (blank_lvl == 1) exp_q.push_back(INVULN);

        repeat (3) step();
        check_reset_vals("reset");
        reset = 1'b0;

        repeat ($urandom_range(5, 20)) step();
        check("idle_stop", stop_gameN, 1'b1);
        check("idle_no_hit", n_coll, 0);

        // HP of 0 while playing is not acted on.
        hp = 2'd0;
        repeat (4 * fp + 3) step();
        check("hp0_play_game_over", game_over, 1'b0);
        check("hp0_play_stop", stop_gameN, 1'b1);
        hp = 2'd3;

        // First hit, collision held through death pause and INVULN.
        n_coll = 0;
        dying_frames = 0;
        raw_collision = 1'b1;
        step();
        check("hit1_pulse", collision_mp, 1'b1);
        check("hit1_stop", stop_gameN, 1'b1);
        step();
        check("hit1_pulse_end", collision_mp, 1'b0);
        check("hit1_frozen", stop_gameN, 1'b0);
        wait_respawn("hit1");
        check("hit1_dying_frames", dying_frames, DEATH);
        check("hit1_single_pulse", n_coll, 1);
        check("hit1_hp", hp, 2'd2);
        check("hit1_resp_stop", stop_gameN, 1'b0);
        check("hit1_no_game_over", game_over, 1'b0);
        n_coll = 0;
        run_invuln("inv1");
        check("inv1_no_hit", n_coll, 0);
        check("inv1_no_pulse", collision_mp, 1'b0);
        step();
        check("replay_hit", collision_mp, 1'b1);
        raw_collision = 1'b0;
        wait_respawn("hit2");
        check("hit2_hp", hp, 2'd1);
        run_invuln("inv2");

        // Last life: collision arrives together with a frame pulse.
        repeat ($urandom_range(3, 15)) step();
        while (phase != fp - 1) step();
        n_coll = 0;
        n_resp = 0;
        n_reload = 0;
        dying_frames = 0;
        raw_collision = 1'b1;
        step();
        raw_collision = 1'b0;
        check("sim_hit", collision_mp, 1'b1);
        restart_req = 1'b1;
        b = 0;
        while (!game_over && b < LIMIT) begin
            step();
            b++;
        end
        check("go_entered", game_over, 1'b1);
        check("go_dying_frames", dying_frames, DEATH);
        check("go_hp", hp, 2'd0);
        check("go_stop", stop_gameN, 1'b0);
        check("go_blank", pacman_blank, 1'b0);
        check("go_no_respawn", n_resp, 0);
        check("go_single_pulse", n_coll, 1);
        check("go_restart_ignored", n_reload, 0);

        repeat ($urandom_range(5, 30)) step();
        check("held_key_game_over", game_over, 1'b1);
        check("held_key_no_reload", n_reload, 0);
        restart_req = 1'b0;
        repeat ($urandom_range(2, 6)) step();
        check("released_game_over", game_over, 1'b1);
        restart_req = 1'b1;
        step();
        check("restart_hp_reload", hp_reload, 1'b1);
        check("restart_respawn", respawn, 1'b1);
        check("restart_game_over", game_over, 1'b0);
        check("restart_stop", stop_gameN, 1'b0);
        step();
        restart_req = 1'b0;
        check("play_hp_reload", hp_reload, 1'b0);
        check("play_game_over", game_over, 1'b0);
        check("play_stop", stop_gameN, 1'b1);
        check("play_hp", hp, 2'd3);

        // Asynchronous reset in the middle of the death pause.
        dying_frames = 0;
        raw_collision = 1'b1;
        step();
        raw_collision = 1'b0;
        b = 0;
        while (dying_frames < 30 && b < LIMIT) begin
            step();
            b++;
        end
        check("mid_dying_frames", dying_frames, 30);
        check("mid_dying_stop", stop_gameN, 1'b0);
        reset = 1'b1;
        #2;
        check_reset_vals("rst_mid");
        #2;
        reset = 1'b0;
        step();
        check("post_rst_stop", stop_gameN, 1'b1);
        raw_collision = 1'b1;
        step();
        check("post_rst_hit", collision_mp, 1'b1);
        raw_collision = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hp_life_sequencer.md
Name: hp_life_sequencer

Overview:
- Drives the HP counter's inputs and reads its HP output.
- Converts the raw per-pixel Pac-Man/monster overlap into one single-cycle collision_mp pulse per hit.
- Freezes gameplay via stop_gameN for a death pause, then respawns Pac-Man with a blinking invulnerability window.
- Enters game-over when HP reaches 0. Sits between the collision detector and the HP counter / object movement blocks.

Parameters:
- DEATH_FRAMES, 60: frames gameplay stays frozen after a hit (≥1).
- INVULN_FRAMES, 120: frames of post-respawn collision immunity (≥1).
- BLINK_FRAMES, 8: frames per blink half-period during invulnerability (≥1).
- CNT_W, 8: width of the frame counter; must hold max(DEATH_FRAMES, INVULN_FRAMES).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_of_frame  in  1  one-cycle pulse per video frame
- raw_collision  in  1  level; Pac-Man overlaps a monster (may stay high many cycles)
- HP  in  2  current HP from the HP counter
- restart_req  in  1  level; player restart key
- collision_mp  out  1  one-cycle hit pulse to the HP counter
- stop_gameN  out  1  active-low freeze to HP counter and movers
- respawn  out  1  one-cycle pulse; movers reload start positions
- hp_reload  out  1  one-cycle pulse; reloads the HP counter to its initial HP
- pacman_blank  out  1  high = hide Pac-Man sprite (blink)
- game_over  out  1  level, high while in GAME_OVER

Behaviour:
- All outputs are registered.
- Reset values: state PLAY, frame counter 0, collision_mp 0, stop_gameN 1, respawn 0, hp_reload 0, pacman_blank 0, game_over 0. Reset may occur in any state and forces these values immediately.
- PLAY: stop_gameN=1. raw_collision=1 → HIT on the next edge.
- HIT, one cycle: collision_mp=1, stop_gameN=1, so the counter decrements. Next state DYING, counter cleared.
- DYING: stop_gameN=0.
  - Each start_of_frame increments the counter.
  - On the start_of_frame where counter==DEATH_FRAMES-1, sample HP (already updated by the hit): HP==0 → GAME_OVER; else → RESPAWN.
- RESPAWN, one cycle: respawn=1, stop_gameN=0. Next state INVULN, counter cleared, pacman_blank=1.
- INVULN: stop_gameN=1. raw_collision is ignored, and collision_mp never pulses.
  - Each start_of_frame increments the counter.
  - pacman_blank toggles on every start_of_frame where (counter+1) mod BLINK_FRAMES==0.
  - On the start_of_frame where counter==INVULN_FRAMES-1 → PLAY, with pacman_blank forced to 0 and the counter cleared.
- GAME_OVER: game_over=1, stop_gameN=0, pacman_blank=0.
  - restart_req is edge-detected: a 0→1 transition while in GAME_OVER → RESTART.
  - A restart_req already high on entry does not trigger until released and re-pressed.
- RESTART, one cycle: hp_reload=1, respawn=1, stop_gameN=0, game_over=0. Next state PLAY.
- restart_req is ignored outside GAME_OVER.
- Simultaneous events:
  - raw_collision together with start_of_frame in PLAY → HIT; the frame pulse has no other effect.
  - raw_collision held high across the whole HIT/DYING sequence produces exactly one collision_mp.
  - If raw_collision is still high on the first PLAY cycle after INVULN, a new hit is taken.
- HP==0 observed in PLAY (e.g. after an external load) is not acted on; only the DYING exit checks HP.
- Counter arithmetic is unsigned CNT_W bits. It never wraps in legal operation because it is cleared on each state entry.

Test Plan:
- Reset mid-DYING (frame 30): assert reset → outputs return to reset values the same cycle; after release, state PLAY.
- HP=3, raw_collision high for 500 cycles → exactly one collision_mp pulse, the cycle after rise; stop_gameN low for 60 frames; then a respawn pulse; HP reads 2.
- After respawn, raw_collision held high throughout INVULN → no collision_mp for 120 frames.
  - pacman_blank toggles at frames 8, 16, … 112, then is 0 at PLAY entry.
  - collision_mp pulses on the first PLAY cycle.
- HP=1 with a hit → HP becomes 0; after 60 frames game_over=1, stop_gameN=0, no respawn pulse.
- In GAME_OVER with restart_req already high → nothing happens. After release and re-press → one cycle of hp_reload=1 and respawn=1, then PLAY with game_over=0.
- raw_collision and start_of_frame in the same cycle in PLAY → HIT next cycle; the DYING frame count starts at 0.
